// File: rtl/tick_gen_pkg.sv
// Shared defaults for the multi-channel tick generator.
// A divider value equal to TG_DIV_STOPPED parks a channel.
package tick_gen_pkg;

  localparam int unsigned TG_WIDTH_DEF   = 32;
  localparam int unsigned TG_NCH_DEF     = 4;
  localparam int unsigned TG_CHW_DEF     = 4;
  localparam int unsigned TG_DIV_DEFAULT = 6_000_000;
  localparam int unsigned TG_DIV_STOPPED = 0;

endpackage

// File: rtl/tick_gen_chan.sv
// One tick-generator channel: divider register, down counter, tick strobe,
// square wave and busy flag, with optional one-shot behaviour.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned      WIDTH       = TG_WIDTH_DEF,
  parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(TG_DIV_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             oneshot_i,
  input  logic             arm_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] STOP    = WIDTH'(TG_DIV_STOPPED);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_RST = (DIV_DEFAULT == STOP) ? '0 : DIV_DEFAULT - ONE;

  // A stopped divider reloads to 0 so the counter never underflows.
  function automatic logic [WIDTH-1:0] reload_val(input logic [WIDTH-1:0] d);
    return (d == STOP) ? '0 : d - ONE;
  endfunction

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             done_q, done_d;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    done_d = done_q && oneshot_i;
    if (load_i) div_d = load_val_i;

    if (sync_i) begin
      cnt_d  = reload_val(div_d);
      sq_d   = 1'b0;
      done_d = 1'b0;
    end else if (load_i && (div_q == STOP || load_val_i == STOP)) begin
      // Starting or stopping a channel acts immediately; other loads wait for the reload.
      cnt_d = reload_val(load_val_i);
    end else if (arm_i) begin
      cnt_d  = reload_val(div_q);
      done_d = 1'b0;
    end else if (div_q == STOP) begin
      cnt_d = '0;
    end else if (en_i && !done_q) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (oneshot_i) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = div_q - ONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_DEFAULT;
      cnt_q  <= CNT_RST;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      done_q <= done_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign busy_o = (div_q != STOP) && !done_q;

endmodule

// File: rtl/tick_gen_multi.sv
// NCH-channel programmable tick generator: LOAD decode and SYNC/EN fan-out.
// Define TICK_GEN_ONESHOT_EN to add the per-channel ONESHOT and ARM inputs.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned      WIDTH       = TG_WIDTH_DEF,
  parameter int unsigned      NCH         = TG_NCH_DEF,
  parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(TG_DIV_DEFAULT),
  parameter int unsigned      CHW         = TG_CHW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             LOAD,
  input  logic [CHW-1:0]   LOAD_CH,
  input  logic [WIDTH-1:0] LOAD_VAL,
`ifdef TICK_GEN_ONESHOT_EN
  input  logic [NCH-1:0]   ONESHOT,
  input  logic [NCH-1:0]   ARM,
`endif
  output logic [NCH-1:0]   TICK,
  output logic [NCH-1:0]   SQ,
  output logic [NCH-1:0]   BUSY
);

  logic [NCH-1:0] load_hit;
  logic [NCH-1:0] oneshot_w;
  logic [NCH-1:0] arm_w;

  // Selects outside 0..NCH-1 match no channel, so such writes are dropped.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      load_hit[i] = LOAD && (LOAD_CH == CHW'(i));
    end
  end

`ifdef TICK_GEN_ONESHOT_EN
  assign oneshot_w = ONESHOT;
  assign arm_w     = ARM;
`else
  assign oneshot_w = '0;
  assign arm_w     = '0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    tick_gen_chan #(
      .WIDTH       (WIDTH),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk        (CLK),
      .rst_n      (RST),
      .en_i       (EN),
      .sync_i     (SYNC),
      .load_i     (load_hit[g]),
      .load_val_i (LOAD_VAL),
      .oneshot_i  (oneshot_w[g]),
      .arm_i      (arm_w[g]),
      .tick_o     (TICK[g]),
      .sq_o       (SQ[g]),
      .busy_o     (BUSY[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: expectations are queued per cycle and
// checked by an independent monitor on the falling clock edge.
module tb_tick_gen_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        SYNC;
  logic        LOAD;
  logic [3:0]  LOAD_CH;
  logic [31:0] LOAD_VAL;
  logic [3:0]  TICK, SQ, BUSY;
`ifdef TICK_GEN_ONESHOT_EN
  logic [3:0]  ONESHOT;
  logic [3:0]  ARM;
`endif

  tick_gen_multi #(
    .WIDTH       (32),
    .NCH         (4),
    .DIV_DEFAULT (32'd4),
    .CHW         (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .SYNC     (SYNC),
    .LOAD     (LOAD),
    .LOAD_CH  (LOAD_CH),
    .LOAD_VAL (LOAD_VAL),
`ifdef TICK_GEN_ONESHOT_EN
    .ONESHOT  (ONESHOT),
    .ARM      (ARM),
`endif
    .TICK     (TICK),
    .SQ       (SQ),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    cyc;
    int    ch;
    logic  tick;
    logic  busy;
    logic  sq;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic finish_req = 1'b0;
  logic mon_done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compares every queued expectation that falls due this cycle.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_vec = n_vec + 1;
        if (sb[i].cyc != cyc || TICK[sb[i].ch] !== sb[i].tick ||
            BUSY[sb[i].ch] !== sb[i].busy || SQ[sb[i].ch] !== sb[i].sq) begin
          n_bad = n_bad + 1;
          $display("FAIL %s cyc=%0d ch=%0d: tick/busy/sq got %b/%b/%b want %b/%b/%b",
                   sb[i].nm, sb[i].cyc, sb[i].ch, TICK[sb[i].ch], BUSY[sb[i].ch],
                   SQ[sb[i].ch], sb[i].tick, sb[i].busy, sb[i].sq);
        end
        sb.delete(i);
      end
    end
    if (finish_req && !mon_done) begin
      n_vec = n_vec + 1;
      if (sb.size() != 0) begin
        n_bad = n_bad + 1;
        $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic expect_at(input int at, input int ch, input logic t, input logic b,
                           input logic s, input string nm);
    exp_t e;
    e.cyc = at; e.ch = ch; e.tick = t; e.busy = b; e.sq = s; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load(input int ch, input int unsigned val);
    LOAD = 1'b1; LOAD_CH = 4'(ch); LOAD_VAL = val;
    step(1);
    LOAD = 1'b0;
  endtask

  task automatic do_sync();
    SYNC = 1'b1;
    step(1);
    SYNC = 1'b0;
  endtask

  task automatic sync_load(input int ch, input int unsigned val);
    SYNC = 1'b1; LOAD = 1'b1; LOAD_CH = 4'(ch); LOAD_VAL = val;
    step(1);
    SYNC = 1'b0; LOAD = 1'b0;
  endtask

  initial begin
    int s;
    RST = 1'b0; EN = 1'b1; SYNC = 1'b0; LOAD = 1'b0; LOAD_CH = '0; LOAD_VAL = '0;
`ifdef TICK_GEN_ONESHOT_EN
    ONESHOT = '0; ARM = '0;
`endif
    step(2);
    for (int c = 0; c < 4; c++) expect_at(cyc, c, 1'b0, 1'b1, 1'b0, "reset");

    // Reset release, D = 4: ticks 4, 8, 12 cycles after release
    RST = 1'b1; s = cyc;
    expect_at(s + 3,  0, 1'b0, 1'b1, 1'b0, "rst_pre");
    expect_at(s + 4,  0, 1'b1, 1'b1, 1'b1, "rst_t1");
    expect_at(s + 5,  0, 1'b0, 1'b1, 1'b1, "rst_post");
    expect_at(s + 7,  0, 1'b0, 1'b1, 1'b1, "rst_pre2");
    expect_at(s + 8,  0, 1'b1, 1'b1, 1'b0, "rst_t2");
    expect_at(s + 11, 0, 1'b0, 1'b1, 1'b0, "rst_pre3");
    expect_at(s + 12, 0, 1'b1, 1'b1, 1'b1, "rst_t3");
    expect_at(s + 4,  3, 1'b1, 1'b1, 1'b1, "rst_ch3_t1");
    expect_at(s + 8,  3, 1'b1, 1'b1, 1'b0, "rst_ch3_t2");
    step(12);

    // LOAD ch1 = 3 while its counter is at 2
    do_sync(); s = cyc;
    expect_at(s,      1, 1'b0, 1'b1, 1'b0, "sync_state");
    expect_at(s + 4,  1, 1'b1, 1'b1, 1'b1, "ld_old_period");
    expect_at(s + 5,  1, 1'b0, 1'b1, 1'b1, "ld_gap1");
    expect_at(s + 6,  1, 1'b0, 1'b1, 1'b1, "ld_gap2");
    expect_at(s + 7,  1, 1'b1, 1'b1, 1'b0, "ld_new_t1");
    expect_at(s + 8,  1, 1'b0, 1'b1, 1'b0, "ld_gap3");
    expect_at(s + 10, 1, 1'b1, 1'b1, 1'b1, "ld_new_t2");
    expect_at(s + 4,  0, 1'b1, 1'b1, 1'b1, "ld_ch0_t1");
    expect_at(s + 7,  0, 1'b0, 1'b1, 1'b1, "ld_ch0_quiet");
    expect_at(s + 8,  0, 1'b1, 1'b1, 1'b0, "ld_ch0_t2");
    step(1);
    load(1, 3);
    step(9);

    // EN low for 5 cycles with ch0 at cnt = 1
    do_sync(); s = cyc;
    expect_at(s + 4,  0, 1'b0, 1'b1, 1'b0, "en_hold_a");
    expect_at(s + 6,  0, 1'b0, 1'b1, 1'b0, "en_hold_b");
    expect_at(s + 8,  0, 1'b0, 1'b1, 1'b0, "en_resume0");
    expect_at(s + 9,  0, 1'b1, 1'b1, 1'b1, "en_tick");
    expect_at(s + 12, 0, 1'b0, 1'b1, 1'b1, "en_gap");
    expect_at(s + 13, 0, 1'b1, 1'b1, 1'b0, "en_tick2");
    expect_at(s + 3,  1, 1'b0, 1'b1, 1'b0, "en_ch1_held");
    expect_at(s + 8,  1, 1'b1, 1'b1, 1'b1, "en_ch1_tick");
    expect_at(s + 11, 1, 1'b1, 1'b1, 1'b0, "en_ch1_tick2");
    step(2);
    EN = 1'b0;
    step(5);
    EN = 1'b1;
    step(7);

    // Stop ch2 with D = 0, then restart it with D = 2
    do_sync(); s = cyc;
    load(2, 0);
    expect_at(s + 1, 2, 1'b0, 1'b0, 1'b0, "stop_a");
    expect_at(s + 4, 2, 1'b0, 1'b0, 1'b0, "stop_b");
    expect_at(s + 8, 2, 1'b0, 1'b0, 1'b0, "stop_c");
    step(8);
    expect_at(s + 9, 2, 1'b0, 1'b0, 1'b0, "stop_d");
    load(2, 2);
    expect_at(s + 10, 2, 1'b0, 1'b1, 1'b0, "restart_busy");
    expect_at(s + 11, 2, 1'b0, 1'b1, 1'b0, "restart_gap");
    expect_at(s + 12, 2, 1'b1, 1'b1, 1'b1, "restart_t1");
    expect_at(s + 13, 2, 1'b0, 1'b1, 1'b1, "restart_gap2");
    expect_at(s + 14, 2, 1'b1, 1'b1, 1'b0, "restart_t2");
    expect_at(s + 16, 2, 1'b1, 1'b1, 1'b1, "restart_t3");
    step(6);

    // Drift at D = 3/5/7, then SYNC with LOAD ch0 = 6, then an out-of-range LOAD
    load(2, 5);
    load(3, 7);
    step(17);
    sync_load(0, 6); s = cyc;
    for (int c = 0; c < 4; c++) expect_at(s, c, 1'b0, 1'b1, 1'b0, "sync_all");
    expect_at(s + 5,  0, 1'b0, 1'b1, 1'b0, "sy_ch0_pre");
    expect_at(s + 6,  0, 1'b1, 1'b1, 1'b1, "sy_ch0_t1");
    expect_at(s + 12, 0, 1'b1, 1'b1, 1'b0, "sy_ch0_t2");
    expect_at(s + 2,  1, 1'b0, 1'b1, 1'b0, "sy_ch1_pre");
    expect_at(s + 3,  1, 1'b1, 1'b1, 1'b1, "sy_ch1_t1");
    expect_at(s + 9,  1, 1'b1, 1'b1, 1'b1, "sy_ch1_t3");
    expect_at(s + 4,  2, 1'b0, 1'b1, 1'b0, "sy_ch2_pre");
    expect_at(s + 5,  2, 1'b1, 1'b1, 1'b1, "sy_ch2_t1");
    expect_at(s + 10, 2, 1'b1, 1'b1, 1'b0, "sy_ch2_t2");
    expect_at(s + 6,  3, 1'b0, 1'b1, 1'b0, "sy_ch3_pre");
    expect_at(s + 7,  3, 1'b1, 1'b1, 1'b1, "sy_ch3_t1");
    expect_at(s + 13, 3, 1'b0, 1'b1, 1'b1, "badch_ch3_pre");
    expect_at(s + 14, 3, 1'b1, 1'b1, 1'b0, "badch_ch3_t2");
    load(15, 9);
    step(13);

    // D = 1: tick every cycle, SQ toggles every cycle
    sync_load(1, 1); s = cyc;
    expect_at(s,     1, 1'b0, 1'b1, 1'b0, "d1_sync");
    expect_at(s + 1, 1, 1'b1, 1'b1, 1'b1, "d1_t1");
    expect_at(s + 2, 1, 1'b1, 1'b1, 1'b0, "d1_t2");
    expect_at(s + 3, 1, 1'b1, 1'b1, 1'b1, "d1_t3");
    step(4);

`ifdef TICK_GEN_ONESHOT_EN
    ONESHOT = 4'b0001;
    sync_load(0, 4); s = cyc;
    expect_at(s,     0, 1'b0, 1'b1, 1'b0, "os_arm");
    expect_at(s + 4, 0, 1'b1, 1'b0, 1'b1, "os_tick");
    expect_at(s + 5, 0, 1'b0, 1'b0, 1'b1, "os_silent_a");
    expect_at(s + 8, 0, 1'b0, 1'b0, 1'b1, "os_silent_b");
    step(9);
    ARM = 4'b0001;
    step(1);
    ARM = 4'b0000;
    s = cyc;
    expect_at(s,     0, 1'b0, 1'b1, 1'b1, "os_rearm");
    expect_at(s + 4, 0, 1'b1, 1'b0, 1'b0, "os_tick2");
    expect_at(s + 8, 0, 1'b0, 1'b0, 1'b0, "os_silent_c");
    step(9);
`endif

    finish_req = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
